adder_stim_checker: RTL
=======================

ADDER_STIM_CHECKER -- requirements
Module: adder_stim_checker

Interface
REQ-001 Parameter SETTLE, default 2, SHALL set the number of WAIT cycles between driving a vector and sampling the result; legal range 1..15.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level-sampled request to run one full sweep.
REQ-005 A  output  3  operand A to the 3-bit registered adder.
REQ-006 B  output  3  operand B to the adder.
REQ-007 Cin  output  1  carry-in to the adder.
REQ-008 Sum_in  input  3  registered sum returned by the adder.
REQ-009 Cout_in  input  1  registered carry-out returned by the adder.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high in DONE state until the next sweep starts or reset.
REQ-012 pass  output  1  valid while done is high; 1 = zero mismatches.
REQ-013 err_count  output  8  number of mismatching vectors in the current or last sweep.
REQ-014 vec_idx  output  7  index of the vector currently driven.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-016 IDLE or DONE with start=1 SHALL go to DRIVE, clear err_count and vec_idx, set busy; start SHALL be ignored in DRIVE/WAIT/CHECK.
REQ-017 Vector mapping SHALL be A=vec_idx[2:0], B=vec_idx[5:3], Cin=vec_idx[6]; all 128 vectors SHALL be applied in ascending index order.
REQ-018 A, B, Cin SHALL be registers, updated only on the edge entering DRIVE, and held stable through WAIT and CHECK.
REQ-019 DRIVE SHALL last 1 cycle, WAIT exactly SETTLE cycles, CHECK 1 cycle; one vector SHALL take SETTLE+2 cycles, one sweep 128*(SETTLE+2) cycles.
REQ-020 Expected result SHALL be the 4-bit value A+B+Cin; CHECK SHALL compare {Cout_in,Sum_in} against it.
REQ-021 A mismatch SHALL increment err_count by 1 on the CHECK exit edge; a vector counts at most once; maximum value is 128, so no wrap occurs.
REQ-022 CHECK with vec_idx<127 SHALL increment vec_idx and go to DRIVE; CHECK with vec_idx=127 SHALL go to DONE without wrapping vec_idx.
REQ-023 Entering DONE SHALL drop busy, raise done, and set pass=(final err_count==0), the final CHECK's mismatch included.
REQ-024 From DONE, start=1 SHALL restart the sweep (REQ-016) and drop done on the same edge; otherwise DONE holds.

Reset
REQ-025 rst=0 SHALL asynchronously force IDLE, A=0, B=0, Cin=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, regardless of state.
REQ-026 Reset mid-sweep SHALL abandon the sweep; after release no sweep SHALL start until start=1 is sampled in IDLE.

Configuration
REQ-027 Macro ADDER_CHK_STOP_ON_FAIL_EN defined: the first mismatch in CHECK SHALL go directly to DONE with err_count=1, pass=0, and vec_idx frozen at the failing index.
REQ-028 Macro ADDER_CHK_STOP_ON_FAIL_EN undefined: all 128 vectors SHALL always be applied, with behaviour exactly as in REQ-015..REQ-024.

Verification
REQ-029 Reset: assert rst=0 mid-sweep at vec_idx=40 -> all outputs at reset values immediately; no activity until start.
REQ-030 Ideal registered-adder model, SETTLE=2, 1-cycle start pulse -> done=1 exactly 512 cycles after the start edge, pass=1, err_count=0.
REQ-031 Model with Sum_in[0] stuck at 0, macro undefined -> done=1, pass=0, err_count=64.
REQ-032 Model with Cout_in stuck at 0, macro undefined -> err_count=64, pass=0.
REQ-033 start held high throughout a sweep -> single sweep of 512 cycles; start still high in DONE -> new sweep with err_count cleared to 0.
REQ-034 Macro defined, Sum_in[0] stuck at 0 -> DONE after vector 1 (A=1,B=0,Cin=0), vec_idx=1, err_count=1, pass=0.

Source files
------------

// File: rtl/adder_stim_checker_if.sv
// Stimulus/response bus between the sweep checker (master) and the 3-bit
// registered adder under test (slave).
interface adder_stim_checker_if;
  logic [2:0] A;
  logic [2:0] B;
  logic       Cin;
  logic [2:0] Sum_in;
  logic       Cout_in;

  modport master (output A, B, Cin, input  Sum_in, Cout_in);
  modport slave  (input  A, B, Cin, output Sum_in, Cout_in);
endinterface

// File: rtl/adder_stim_checker.sv
// Exhaustive 128-vector sweep of a 3-bit registered adder with mismatch count.
// Optional ADDER_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module adder_stim_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  adder_stim_checker_if.master   bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [7:0]             err_count,
  output logic [6:0]             vec_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] LP_WLAST = 4'(SETTLE - 1);

  logic [2:0] r_state;
  logic [3:0] r_wait;
  logic [6:0] r_idx;
  logic [7:0] r_err;
  logic [2:0] r_a, r_b;
  logic       r_cin, r_busy, r_done, r_pass;

  logic [3:0] w_exp;
  logic       w_mis;
  logic [6:0] w_idx_nxt;
  logic       w_last;

  assign w_exp     = {1'b0, r_a} + {1'b0, r_b} + {3'b000, r_cin};
  assign w_mis     = ({bus.Cout_in, bus.Sum_in} != w_exp);
  assign w_idx_nxt = r_idx + 7'd1;
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
  assign w_last    = (r_idx == 7'd127) || w_mis;
`else
  assign w_last    = (r_idx == 7'd127);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_idx   <= '0;
      r_err   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_DRIVE;
            r_idx   <= '0;
            r_err   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_state <= S_WAIT;
          r_wait  <= '0;
        end
        S_WAIT: begin
          if (r_wait == LP_WLAST) r_state <= S_CHECK;
          else                    r_wait  <= r_wait + 4'd1;
        end
        S_CHECK: begin
          if (w_mis) r_err <= r_err + 8'd1;
          if (w_last) begin
            // pass must include this final vector's result, not yet in r_err
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == 8'd0) && !w_mis;
          end else begin
            r_state <= S_DRIVE;
            r_idx   <= w_idx_nxt;
            r_a     <= w_idx_nxt[2:0];
            r_b     <= w_idx_nxt[5:3];
            r_cin   <= w_idx_nxt[6];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.A     = r_a;
  assign bus.B     = r_b;
  assign bus.Cin   = r_cin;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign vec_idx   = r_idx;

endmodule
